// File: rtl/inst_mem_pkg.sv
// ---------------------------------------------------------------------------
// inst_mem_pkg
// Shared types and address helpers for the instruction line memory.
//   line_off()   : byte-offset bits covered by one line
//   idx_w()      : bits needed to index DEPTH lines (min 1)
//   line_index() : line number of a byte address plus an in-range flag
//   word_t/line_t: default-width word and line types
// ---------------------------------------------------------------------------
package inst_mem_pkg;

  localparam int unsigned DEF_WORD_W         = 32;
  localparam int unsigned DEF_WORDS_PER_LINE = 4;

  typedef logic [DEF_WORD_W-1:0]                    word_t;
  typedef logic [DEF_WORD_W*DEF_WORDS_PER_LINE-1:0] line_t;

  typedef struct packed {
    logic        in_range;
    logic [31:0] idx;
  } line_idx_t;

  function automatic int unsigned line_off(input int unsigned word_w,
                                           input int unsigned words_per_line);
    return $clog2((words_per_line * word_w) / 8);
  endfunction

  function automatic int unsigned idx_w(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  // Every upper address bit takes part in the range test, so aliased
  // addresses above the array are flagged rather than wrapped.
  function automatic line_idx_t line_index(input logic [63:0]   addr,
                                           input int unsigned   loff,
                                           input int unsigned   depth);
    line_idx_t   r;
    logic [63:0] lnum;
    lnum       = addr >> loff;
    r.in_range = (lnum < 64'(depth));
    r.idx      = 32'(lnum & 64'(depth - 1));
    return r;
  endfunction

endpackage

// File: rtl/inst_line_mem_resp_fifo.sv
// ---------------------------------------------------------------------------
// resp_fifo
// Synchronous FIFO holding completed fetch responses.
//   clk_i, rst_ni     : clock, async active-low reset
//   flush_i           : empty the FIFO at the next edge (wins over push/pop)
//   push_i/push_data_i: write one entry
//   pop_i             : consume the head when valid_o
//   valid_o/data_o    : head entry, held until popped
// A push into a full FIFO is accepted when a pop happens in the same cycle.
// ---------------------------------------------------------------------------
module resp_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 3
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  output logic             valid_o,
  output logic [WIDTH-1:0] data_o
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] rd_q, rd_d;
  logic [PTR_W-1:0] wr_q, wr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             do_push, do_pop;

  // Depth need not be a power of two, so pointers wrap explicitly.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign valid_o = (cnt_q != '0);
  assign data_o  = mem_q[rd_q];

  always_comb begin
    do_pop  = pop_i && valid_o && !flush_i;
    do_push = push_i && !flush_i && ((cnt_q != CNT_W'(DEPTH)) || do_pop);
    rd_d    = rd_q;
    wr_d    = wr_q;
    cnt_d   = cnt_q;
    if (flush_i) begin
      rd_d  = '0;
      wr_d  = '0;
      cnt_d = '0;
    end else begin
      if (do_pop)  rd_d = ptr_inc(rd_q);
      if (do_push) wr_d = ptr_inc(wr_q);
      cnt_d = cnt_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
    end else begin
      rd_q  <= rd_d;
      wr_q  <= wr_d;
      cnt_q <= cnt_d;
      if (do_push) mem_q[wr_q] <= push_data_i;
    end
  end

endmodule

// File: rtl/inst_line_mem.sv
// ---------------------------------------------------------------------------
// inst_line_mem
// Instruction memory returning one full line per fetch, with a fixed-latency
// read pipeline feeding a response FIFO.
//   clk, rst_n            : clock, async active-low reset
//   req_valid/req_ready   : fetch request handshake, req_addr is a byte address
//   resp_valid/resp_ready : response handshake, resp_line (word 0 in LSBs),
//                           resp_err flags an address beyond the array
//   flush                 : drop every in-flight and buffered response
//   load_en/addr/word     : single-word program load, ignored out of range
// ---------------------------------------------------------------------------
module inst_line_mem
  import inst_mem_pkg::*;
#(
  parameter int unsigned ADDR_W         = 32,
  parameter int unsigned WORD_W         = 32,
  parameter int unsigned WORDS_PER_LINE = 4,
  parameter int unsigned DEPTH_LINES    = 64,
  parameter int unsigned LATENCY        = 2
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             req_valid,
  output logic                             req_ready,
  input  logic [ADDR_W-1:0]                req_addr,
  output logic                             resp_valid,
  input  logic                             resp_ready,
  output logic [WORD_W*WORDS_PER_LINE-1:0] resp_line,
  output logic                             resp_err,
  input  logic                             flush,
  input  logic                             load_en,
  input  logic [ADDR_W-1:0]                load_addr,
  input  logic [WORD_W-1:0]                load_word
);

  localparam int unsigned LINE_W = WORD_W * WORDS_PER_LINE;
  localparam int unsigned LOFF   = line_off(WORD_W, WORDS_PER_LINE);
  localparam int unsigned IDXW   = idx_w(DEPTH_LINES);
  localparam int unsigned WLSB   = $clog2(WORD_W / 8);
  localparam int unsigned WOFF_W = (WORDS_PER_LINE > 1) ? $clog2(WORDS_PER_LINE) : 1;
  localparam int unsigned SLOTS  = LATENCY + 1;
  localparam int unsigned CNT_W  = $clog2(SLOTS + 1);

  logic [LINE_W-1:0] mem_q [DEPTH_LINES];

  line_idx_t         rq, ld;
  logic [IDXW-1:0]   rq_idx, ld_idx;
  logic [WOFF_W-1:0] ld_woff;
  logic [LINE_W-1:0] rd_line;
  logic              req_fire, pop_fire;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic              pipe_vld_q  [LATENCY];
  logic              pipe_err_q  [LATENCY];
  logic [LINE_W-1:0] pipe_line_q [LATENCY];

  logic              fifo_valid;
  logic [LINE_W:0]   fifo_data;
  logic              unused_idx_bits;

  assign rq      = line_index(64'(req_addr),  LOFF, DEPTH_LINES);
  assign ld      = line_index(64'(load_addr), LOFF, DEPTH_LINES);
  assign rq_idx  = rq.idx[IDXW-1:0];
  assign ld_idx  = ld.idx[IDXW-1:0];
  assign ld_woff = (WORDS_PER_LINE > 1) ? load_addr[WLSB +: WOFF_W] : '0;

  // Index bits above IDXW are always zero after masking.
  assign unused_idx_bits = ^{rq.idx, ld.idx};

  // cnt covers pipeline plus FIFO, so the FIFO can never overflow and the
  // pipeline never needs to stall.
  assign req_ready = (cnt_q < CNT_W'(SLOTS)) && !flush;
  assign req_fire  = req_valid && req_ready;
  assign pop_fire  = resp_valid && resp_ready;

  assign rd_line = mem_q[rq_idx];

  always_comb begin
    cnt_d = cnt_q;
    if (flush) cnt_d = '0;
    else       cnt_d = cnt_q + CNT_W'(req_fire) - CNT_W'(pop_fire);
  end

  // Contents survive reset; the read above samples before this write lands,
  // giving read-before-write on a same-cycle hit.
  always_ff @(posedge clk) begin
    if (load_en && ld.in_range) begin
      for (int w = 0; w < int'(WORDS_PER_LINE); w++) begin
        if (ld_woff == WOFF_W'(w)) mem_q[ld_idx][w*WORD_W +: WORD_W] <= load_word;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      for (int i = 0; i < int'(LATENCY); i++) begin
        pipe_vld_q[i]  <= 1'b0;
        pipe_err_q[i]  <= 1'b0;
        pipe_line_q[i] <= '0;
      end
    end else begin
      cnt_q          <= cnt_d;
      pipe_vld_q[0]  <= req_fire;
      pipe_err_q[0]  <= !rq.in_range;
      pipe_line_q[0] <= rq.in_range ? rd_line : '0;
      for (int i = 1; i < int'(LATENCY); i++) begin
        pipe_vld_q[i]  <= pipe_vld_q[i-1] && !flush;
        pipe_err_q[i]  <= pipe_err_q[i-1];
        pipe_line_q[i] <= pipe_line_q[i-1];
      end
    end
  end

  resp_fifo #(
    .WIDTH (LINE_W + 1),
    .DEPTH (SLOTS)
  ) u_resp_fifo (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .flush_i     (flush),
    .push_i      (pipe_vld_q[LATENCY-1]),
    .push_data_i ({pipe_err_q[LATENCY-1], pipe_line_q[LATENCY-1]}),
    .pop_i       (resp_ready),
    .valid_o     (fifo_valid),
    .data_o      (fifo_data)
  );

  assign resp_valid = fifo_valid;
  assign resp_err   = fifo_data[LINE_W];
  assign resp_line  = fifo_data[LINE_W-1:0];

endmodule

// File: tb/tb_inst_line_mem.sv
module tb_inst_line_mem;

  localparam int LAT   = 2;
  localparam int SLOTS = LAT + 1;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         req_valid, req_ready;
  logic [31:0]  req_addr;
  logic         resp_valid, resp_ready;
  logic [127:0] resp_line;
  logic         resp_err;
  logic         flush;
  logic         load_en;
  logic [31:0]  load_addr;
  logic [31:0]  load_word;

  inst_line_mem #(
    .ADDR_W(32), .WORD_W(32), .WORDS_PER_LINE(4), .DEPTH_LINES(64), .LATENCY(LAT)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_addr   (req_addr),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_line  (resp_line),
    .resp_err   (resp_err),
    .flush      (flush),
    .load_en    (load_en),
    .load_addr  (load_addr),
    .load_word  (load_word)
  );

  always #5 clk = ~clk;

  // Reference model: word-addressed memory image and a queue of accepted
  // requests, each carrying its expected result and acceptance cycle.
  typedef struct {
    logic [127:0] line;
    logic         err;
    int           acc;
  } exp_t;

  logic [31:0] mem_m [256];
  exp_t        q[$];
  int          cyc    = 0;
  int          n_acc  = 0;
  int          errors = 0;
  int          checks = 0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model_read(input logic [31:0] addr);
    exp_t e;
    int   base;
    e.acc = 0;
    if (addr < 32'h400) begin
      base   = int'(addr >> 4) * 4;
      e.line = {mem_m[base+3], mem_m[base+2], mem_m[base+1], mem_m[base]};
      e.err  = 1'b0;
    end else begin
      e.line = '0;
      e.err  = 1'b1;
    end
    return e;
  endfunction

  // Called at a falling edge with inputs already driven.
  task automatic cycle();
    bit   er, ev, acc, pop;
    exp_t e;
    #1;
    er = (q.size() < SLOTS) && !flush;
    ev = (q.size() > 0) && (cyc >= q[0].acc + LAT);
    chk("req_ready", req_ready, er);
    chk("resp_valid", resp_valid, ev);
    if (ev) begin
      chk("resp_line", resp_line, q[0].line);
      chk("resp_err", resp_err, q[0].err);
    end
    if (req_valid && req_ready) n_acc++;
    acc = req_valid && er;
    pop = ev && resp_ready;
    e   = model_read(req_addr);
    @(posedge clk);
    cyc++;
    if (flush) q.delete();
    else begin
      if (pop) void'(q.pop_front());
      if (acc) begin
        e.acc = cyc;
        q.push_back(e);
      end
    end
    if (load_en && load_addr < 32'h400) mem_m[load_addr[9:2]] = load_word;
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    req_valid = 1'b0; req_addr = '0; resp_ready = 1'b1;
    flush = 1'b0; load_en = 1'b0; load_addr = '0; load_word = '0;
  endtask

  task automatic drain();
    idle_inputs();
    for (int i = 0; i < 20 && q.size() > 0; i++) cycle();
    cycle();
  endtask

  initial begin
    exp_t e;
    rst_n = 1'b0;
    idle_inputs();
    for (int i = 0; i < 256; i++) mem_m[i] = '0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_resp_err", resp_err, 0);
    chk("rst_resp_line", resp_line, 0);
    chk("rst_req_ready", req_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    cycle();

    // Fill the whole array so no read depends on power-up contents.
    load_en = 1'b1;
    for (int i = 0; i < 256; i++) begin
      load_addr = 32'(i * 4);
      load_word = $urandom;
      cycle();
    end
    for (int w = 0; w < 4; w++) begin
      load_addr = 32'h20 + 32'(w * 4);
      load_word = 32'h11111111 * 32'(w + 1);
      cycle();
    end
    load_en = 1'b0;

    // Basic fetch with exact latency.
    req_valid = 1'b1; req_addr = 32'h24;
    cycle();
    req_valid = 1'b0;
    cycle();
    chk("basic_early_valid", resp_valid, 0);
    cycle();
    chk("basic_valid", resp_valid, 1);
    chk("basic_line", resp_line, 128'h44444444_33333333_22222222_11111111);
    chk("basic_err", resp_err, 0);
    drain();

    // Streaming to lines 0..7.
    for (int i = 0; i < 8; i++) begin
      req_valid = 1'b1; req_addr = 32'(i << 4);
      cycle();
    end
    drain();

    // Backpressure.
    resp_ready = 1'b0; req_valid = 1'b1; n_acc = 0;
    for (int i = 0; i < 6; i++) begin
      req_addr = 32'((8 + i) << 4);
      cycle();
    end
    chk("bp_accepts", n_acc, 3);
    resp_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      req_addr = 32'((20 + i) << 4);
      cycle();
    end
    drain();

    // Out of range, including a high-bit alias of line 2.
    req_valid = 1'b1; req_addr = 32'h400;
    cycle();
    req_addr = 32'h0;
    cycle();
    req_addr = 32'h8000_0020;
    cycle();
    req_valid = 1'b0;
    chk("oor_err", resp_err, 1);
    chk("oor_line", resp_line, 0);
    drain();

    // Flush with three outstanding.
    resp_ready = 1'b0; req_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      req_addr = 32'((30 + i) << 4);
      cycle();
    end
    flush = 1'b1; req_addr = 32'h30;
    cycle();
    flush = 1'b0; req_valid = 1'b0; resp_ready = 1'b1;
    chk("flush_valid", resp_valid, 0);
    req_valid = 1'b1; req_addr = 32'h50;
    cycle();
    req_valid = 1'b0;
    cycle();
    cycle();
    chk("flush_new_valid", resp_valid, 1);
    drain();

    // Randomised traffic with loads, flushes and backpressure.
    for (int n = 0; n < 1500; n++) begin
      req_valid  = ($urandom_range(0, 3) != 0);
      req_addr   = ($urandom_range(0, 15) == 0) ? $urandom
                                                : 32'($urandom_range(0, 1023));
      resp_ready = ($urandom_range(0, 3) != 0);
      flush      = ($urandom_range(0, 39) == 0);
      load_en    = ($urandom_range(0, 3) == 0);
      case ($urandom_range(0, 3))
        0:       load_addr = $urandom;
        1:       load_addr = {req_addr[31:4], 4'(($urandom_range(0, 3)) << 2)};
        default: load_addr = 32'($urandom_range(0, 1023));
      endcase
      load_word = $urandom;
      cycle();
    end
    drain();

    // Reset in the middle of a stream.
    resp_ready = 1'b0; req_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      req_addr = 32'(i << 4);
      cycle();
    end
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_valid", resp_valid, 0);
    chk("midrst_line", resp_line, 0);
    chk("midrst_ready", req_ready, 1);
    idle_inputs();
    q.delete();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    cycle();
    req_valid = 1'b1; req_addr = 32'h24;
    e = model_read(32'h24);
    cycle();
    req_valid = 1'b0;
    cycle();
    cycle();
    chk("postrst_valid", resp_valid, 1);
    chk("postrst_line", resp_line, e.line);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
